// File: rtl/board_pkg.sv
// board_pkg: shared constants and types for the board RAM arbiter.
//   BOARD_BASE / BOARD_WORDS / BOARD_LIMIT : byte window of the 100-word board RAM
//   arb_state_e : arbiter FSM states
//   req_id_e    : requester identifiers
package board_pkg;

   localparam logic [31:0] BOARD_BASE  = 32'h1000;
   localparam int unsigned BOARD_WORDS = 100;
   localparam logic [31:0] BOARD_LIMIT = 32'h1190;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      CAPTURE = 3'd2,
      DONE    = 3'd3,
      CLEAR   = 3'd4
   } arb_state_e;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_VID = 1'b1
   } req_id_e;

endpackage

// File: rtl/board_rr_arb2.sv
// board_rr_arb2: two-way round-robin grant.
//   clk, rst     : clock, synchronous active-high reset
//   req_cpu      : CPU requester active
//   req_vid      : display requester active
//   update       : grant accepted this cycle; remember it as last grant
//   grant_valid  : at least one requester active
//   grant        : chosen requester
module board_rr_arb2
   import board_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    req_cpu,
   input  logic    req_vid,
   input  logic    update,
   output logic    grant_valid,
   output req_id_e grant
);

   req_id_e last_grant_q;

   always_comb begin
      grant_valid = req_cpu | req_vid;
      if (req_cpu && req_vid) begin
         // Contention: favour whoever did not win last time.
         grant = (last_grant_q == REQ_CPU) ? REQ_VID : REQ_CPU;
      end else if (req_vid) begin
         grant = REQ_VID;
      end else begin
         grant = REQ_CPU;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= REQ_CPU;
      end else if (update) begin
         last_grant_q <= grant;
      end
   end

endmodule

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares the board RAM between the CPU load/store port and the
// display scanner, and zeroes the whole board on a clear command.
//   clk, rst                          : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata             : CPU request (held until cpu_done)
//   cpu_done/rdata/err                : CPU completion pulse, read data, window miss
//   vid_req/addr                      : display read request (held until vid_done)
//   vid_done/rdata                    : display completion pulse, read data
//   clear_start/busy/done             : bulk-clear command, busy flag, end pulse
//   ram_r/w/addr/wdata, ram_rdata     : board RAM interface (read data one cycle late)
module board_ram_arbiter
   import board_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BOARD_BASE,
   parameter int unsigned NUM_WORDS = BOARD_WORDS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_done,
   output logic [31:0] cpu_rdata,
   output logic        cpu_err,
   input  logic        vid_req,
   input  logic [31:0] vid_addr,
   output logic        vid_done,
   output logic [31:0] vid_rdata,
   input  logic        clear_start,
   output logic        clear_busy,
   output logic        clear_done,
   output logic        ram_r,
   output logic        ram_w,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   localparam logic [31:0] LIMIT    = BASE_ADDR + 32'(NUM_WORDS * 4);
   localparam logic [6:0]  LAST_IDX = 7'(NUM_WORDS - 1);

   arb_state_e  state_q, state_d;
   req_id_e     id_q;
   logic        we_q, miss_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] cpu_rdata_q, vid_rdata_q;
   logic        clear_pend_q, clear_done_q;
   logic [6:0]  clr_cnt_q;

   logic        arb_valid, grant_fire, sel_we, sel_hit;
   req_id_e     arb_id;
   logic [31:0] sel_addr;

   board_rr_arb2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_cpu     (cpu_req),
      .req_vid     (vid_req),
      .update      (grant_fire),
      .grant_valid (arb_valid),
      .grant       (arb_id)
   );

   // A pending clear outranks any request waiting in IDLE.
   assign grant_fire = (state_q == IDLE) && !clear_pend_q && arb_valid;
   assign sel_addr   = (arb_id == REQ_CPU) ? cpu_addr : vid_addr;
   assign sel_we     = (arb_id == REQ_CPU) ? cpu_we : 1'b0;
   assign sel_hit    = (sel_addr >= BASE_ADDR) && (sel_addr < LIMIT) && (sel_addr[1:0] == 2'b00);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (clear_pend_q) state_d = CLEAR;
            else if (arb_valid) state_d = sel_hit ? ISSUE : DONE;
         end
         ISSUE:   state_d = we_q ? DONE : CAPTURE;
         CAPTURE: state_d = DONE;
         DONE:    state_d = IDLE;
         CLEAR:   if (clr_cnt_q == LAST_IDX) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         id_q         <= REQ_CPU;
         we_q         <= 1'b0;
         miss_q       <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cpu_rdata_q  <= '0;
         vid_rdata_q  <= '0;
         clear_pend_q <= 1'b0;
         clear_done_q <= 1'b0;
         clr_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         clear_done_q <= (state_q == CLEAR) && (clr_cnt_q == LAST_IDX);

         if (state_q == IDLE && clear_pend_q) begin
            clear_pend_q <= 1'b0;
         end else if (clear_start && !clear_busy) begin
            clear_pend_q <= 1'b1;
         end

         if (state_q == CLEAR) begin
            clr_cnt_q <= (clr_cnt_q == LAST_IDX) ? 7'd0 : clr_cnt_q + 7'd1;
         end

         if (grant_fire) begin
            id_q    <= arb_id;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= cpu_wdata;
            miss_q  <= !sel_hit;
            // A miss completes next cycle, so the zeroed read data lands with done.
            if (!sel_hit) begin
               if (arb_id == REQ_CPU) cpu_rdata_q <= '0;
               else vid_rdata_q <= '0;
            end
         end

         if (state_q == CAPTURE) begin
            if (id_q == REQ_CPU) cpu_rdata_q <= ram_rdata;
            else vid_rdata_q <= ram_rdata;
         end
      end
   end

   always_comb begin
      ram_r     = 1'b0;
      ram_w     = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (state_q == ISSUE) begin
         ram_addr = addr_q;
         if (we_q) begin
            ram_w     = 1'b1;
            ram_wdata = wdata_q;
         end else begin
            ram_r = 1'b1;
         end
      end else if (state_q == CLEAR) begin
         ram_w    = 1'b1;
         ram_addr = BASE_ADDR + {23'd0, clr_cnt_q, 2'b00};
      end
   end

   assign cpu_done   = (state_q == DONE) && (id_q == REQ_CPU);
   assign vid_done   = (state_q == DONE) && (id_q == REQ_VID);
   assign cpu_err    = cpu_done && miss_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign vid_rdata  = vid_rdata_q;
   assign clear_busy = clear_pend_q || (state_q == CLEAR);
   assign clear_done = clear_done_q;

endmodule
